// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - shared types and constants for the counter scheduler
//
// Purpose: FSM state encoding, legal requester-count bounds and default
//          parameter values used by cnt_sched and rr_arbiter.
// Ports:   none (package).
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_MIN       = 2;
  localparam int N_MAX       = 16;
  localparam int N_DEF       = 4;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/cnt_sched_if.sv
// rtl/cnt_sched_if.sv - requester handshake and counter-control bundle
//
// Purpose: groups the per-requester req/gnt/ack lines, the status outputs and
//          the three counter-control lines of cnt_sched into one bundle.
// Ports:   req[N], cnt_end          : into the scheduler
//          gnt[N], ack[N], err, busy,
//          cnt_en, cnt_rst_b        : out of the scheduler
// Modports: slave  - the scheduler itself
//           master - the requesters/counter environment around it
interface cnt_sched_if #(
  parameter int N = 4
);

  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         err;
  logic         busy;
  logic         cnt_en;
  logic         cnt_rst_b;
  logic         cnt_end;

  modport slave (
    input  req, cnt_end,
    output gnt, ack, err, busy, cnt_en, cnt_rst_b
  );

  modport master (
    output req, cnt_end,
    input  gnt, ack, err, busy, cnt_en, cnt_rst_b
  );

endinterface

// File: rtl/cnt_sched_rr_arbiter.sv
// rtl/cnt_sched_rr_arbiter.sv - round-robin arbiter with internal priority pointer
//
// Purpose: picks the first requesting index at or after the priority pointer,
//          wrapping to 0; on strobe the pointer moves to winner+1 (mod N).
// Ports:   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//          req[N]      : request vector
//          strobe      : a grant is being taken this cycle
//          winner[N]   : one-hot winner, combinational (0 when req is 0)
module rr_arbiter
  import cnt_sched_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         strobe,
  output logic [N-1:0] winner
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;

  // Scan offsets from the highest down to 0 so the smallest offset from the
  // pointer is the last to write, i.e. the one that wins.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(N)) begin
        sum = sum - SUM_W'(N);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (strobe && (req != '0)) begin
      ptr <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - round-robin scheduler owning one shared end-detecting counter
//
// Purpose: grants the shared counter to one requester at a time, pulses the
//          counter reset for one cycle, holds cnt_en for the run and returns
//          a one-hot ack when cnt_end is seen.
// Ports:   clk          : clock, rising edge
//          rst          : synchronous active-high reset
//          bus (slave)  : req/gnt/ack/err/busy and cnt_en/cnt_rst_b/cnt_end
// Config:  CNT_SCHED_WATCHDOG_EN - when defined, a RUN lasting TIMEOUT cycles
//          without cnt_end is aborted with err pulsed alongside ack.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  cnt_sched_if.slave   bus
);

  // An out-of-range configuration shows up as this named block in the
  // elaborated hierarchy.
  if ((N < N_MIN) || (N > N_MAX) || (TIMEOUT < 1)) begin : g_illegal_params
  end

  state_t       state;
  logic [N-1:0] gnt_q;
  logic [N-1:0] ack_q;
  logic         err_q;
  logic         busy_q;
  logic         cnt_en_q;
  logic         cnt_rst_b_q;
  logic [N-1:0] winner;
  logic         grant_now;

  assign grant_now = (state == IDLE) && (bus.req != '0);

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .strobe (grant_now),
    .winner (winner)
  );

`ifdef CNT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // This RUN cycle would bring the count to TIMEOUT.
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_rst_b_q <= 1'b0;
`ifdef CNT_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      ack_q       <= '0;
      err_q       <= 1'b0;
      cnt_rst_b_q <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_now) begin
            gnt_q       <= winner;
            busy_q      <= 1'b1;
            cnt_rst_b_q <= 1'b0;
            state       <= CLR;
          end
        end
        CLR: begin
          cnt_en_q <= 1'b1;
          state    <= RUN;
`ifdef CNT_SCHED_WATCHDOG_EN
          wd_cnt   <= '0;
`endif
        end
        RUN: begin
`ifdef CNT_SCHED_WATCHDOG_EN
          // cnt_end takes precedence over a coincident expiry.
          if (bus.cnt_end || wd_expire) begin
            cnt_en_q <= 1'b0;
            ack_q    <= gnt_q;
            err_q    <= ~bus.cnt_end;
            gnt_q    <= '0;
            state    <= DONE;
          end else begin
            wd_cnt   <= wd_cnt + 1'b1;
          end
`else
          if (bus.cnt_end) begin
            cnt_en_q <= 1'b0;
            ack_q    <= gnt_q;
            gnt_q    <= '0;
            state    <= DONE;
          end
`endif
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.cnt_rst_b = cnt_rst_b_q;

endmodule
